svm_accum: RTL and testbench

- Downstream consumer of the 32-bit fixed-point adder stage in the HOG/SVM classifier datapath.
- Accepts a stream of 32-bit fixed-point feature×weight products and accumulates exactly NUM_TERMS of them per detection window.
- Adds the SVM bias, then presents a held score and a classification bit to the decision logic through a valid/ready handshake.

---
 rtl/svm_pkg.sv | 7 +
 rtl/svm_accum_if.sv | 14 +
 rtl/svm_acc_adder.sv | 13 +
 rtl/svm_accum.sv | 58 +++++
 tb/tb_svm_accum.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/svm_pkg.sv
// svm_pkg: shared fixed-point widths, zero encodings and accumulator state encoding
package svm_pkg;
  localparam int FX_W = 32;
  localparam logic [FX_W-1:0] FX_ZERO = 32'h00000000;
  localparam logic [FX_W-1:0] FX_NEG_ZERO = 32'h80000000;
  typedef enum logic [1:0] {ACCUM = 2'd0, BIAS = 2'd1, HOLD = 2'd2} state_t;
endpackage

// File: rtl/svm_accum_if.sv
// svm_accum_if: product input stream (in_valid/in_ready/in_data) and score output (out_valid/out_ready/out_score/out_class/out_overflow); slave = accumulator side
interface svm_accum_if;
  import svm_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [FX_W-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [FX_W-1:0] out_score;
  logic out_class;
  logic out_overflow;
  modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_score, out_class, out_overflow);
  modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_score, out_class, out_overflow);
endinterface

// File: rtl/svm_acc_adder.sv
// svm_acc_adder: combinational a+b where either zero encoding passes the other operand through; carry only from a real add
module svm_acc_adder
  import svm_pkg::*;
(
  input  logic [FX_W-1:0] a,
  input  logic [FX_W-1:0] b,
  output logic [FX_W-1:0] sum,
  output logic            carry
);
  assign {carry, sum} = (a == FX_ZERO || a == FX_NEG_ZERO) ? {1'b0, b} :
                        (b == FX_ZERO || b == FX_NEG_ZERO) ? {1'b0, a} :
                        {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/svm_accum.sv
// svm_accum: sums NUM_TERMS products per window, adds BIAS, holds score/class/overflow on bus (slave) until taken; clk, reset sync active-high
module svm_accum
  import svm_pkg::*;
#(
  parameter int NUM_TERMS = 3780,
  parameter int CNT_W = 12,
  parameter logic [FX_W-1:0] BIAS = 32'h00000000
) (
  input logic clk,
  input logic reset,
  svm_accum_if.slave bus
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_TERMS - 1);
  state_t state;
  logic [FX_W-1:0] acc, opnd, sum;
  logic [CNT_W-1:0] cnt;
  logic carry, ovf;
  // the package state BIAS is qualified because the bias parameter shadows it
  assign opnd = (state == svm_pkg::BIAS) ? BIAS : bus.in_data;
  svm_acc_adder u_add (.a(acc), .b(opnd), .sum(sum), .carry(carry));
  assign bus.in_ready = (state == ACCUM) && !reset;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ACCUM;
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_score <= '0;
      bus.out_class <= 1'b0;
      bus.out_overflow <= 1'b0;
    end else if (state == ACCUM) begin
      if (bus.in_valid) begin
        acc <= sum;
        ovf <= ovf | carry;
        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        if (cnt == LAST) state <= svm_pkg::BIAS;
      end
    end else if (state == svm_pkg::BIAS) begin
      acc <= sum;
      ovf <= ovf | carry;
      state <= HOLD;
      bus.out_valid <= 1'b1;
      bus.out_score <= sum;
      bus.out_class <= !sum[FX_W-1] && (sum != FX_ZERO);
      bus.out_overflow <= ovf | carry;
    end else if (bus.out_ready) begin
      state <= ACCUM;
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_score <= '0;
      bus.out_class <= 1'b0;
      bus.out_overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_svm_accum.sv
// tb_svm_accum: directed bench for svm_accum with NUM_TERMS=4, BIAS=0 (b0) and BIAS=FFFFFFF0 (b1) fed identical stimulus
module tb_svm_accum;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] in_data = '0;
  int checks = 0;
  int failures = 0;
  svm_accum_if b0();
  svm_accum_if b1();
  assign b0.in_valid = in_valid;
  assign b0.in_data = in_data;
  assign b0.out_ready = out_ready;
  assign b1.in_valid = in_valid;
  assign b1.in_data = in_data;
  assign b1.out_ready = out_ready;
  svm_accum #(.NUM_TERMS(4), .CNT_W(3), .BIAS(32'h00000000)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  svm_accum #(.NUM_TERMS(4), .CNT_W(3), .BIAS(32'hFFFFFFF0)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] d0, d1, d2, d3);
    logic [31:0] d[4];
    d = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = d[i];
      step();
    end
    in_valid = 1'b0;
    in_data = '0;
  endtask

  task automatic ack();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++; if (b0.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", b0.in_ready); end
    checks++; if (b0.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", b0.out_valid); end
    checks++; if ({b0.out_score, b0.out_class, b0.out_overflow} !== 34'h0) begin failures++; $display("FAIL rst_outputs got=%h/%b/%b exp=0", b0.out_score, b0.out_class, b0.out_overflow); end
    reset = 1'b0;
    #1;
    checks++; if (b0.in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_in_ready got=%b exp=1", b0.in_ready); end
  endtask

  task automatic test_basic();
    feed(32'd1, 32'd2, 32'd3, 32'd4);
    checks++; if (b0.out_valid !== 1'b0) begin failures++; $display("FAIL basic_bias_cycle_valid got=%b exp=0", b0.out_valid); end
    checks++; if (b0.in_ready !== 1'b0) begin failures++; $display("FAIL basic_bias_cycle_ready got=%b exp=0", b0.in_ready); end
    step();
    checks++; if (b0.out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", b0.out_valid); end
    checks++; if (b0.out_score !== 32'h0000000A) begin failures++; $display("FAIL basic_score got=%h exp=0000000a", b0.out_score); end
    checks++; if (b0.out_class !== 1'b1 || b0.out_overflow !== 1'b0) begin failures++; $display("FAIL basic_class_ovf got=%b/%b exp=1/0", b0.out_class, b0.out_overflow); end
    checks++; if (b1.out_score !== 32'hFFFFFFFA || b1.out_class !== 1'b0) begin failures++; $display("FAIL basic_bias_score got=%h/%b exp=fffffffa/0", b1.out_score, b1.out_class); end
    ack();
    checks++; if (b0.out_valid !== 1'b0 || b0.in_ready !== 1'b1) begin failures++; $display("FAIL basic_after_ack got=%b/%b exp=0/1", b0.out_valid, b0.in_ready); end
  endtask

  task automatic test_negzero();
    feed(32'h80000000, 32'd5, 32'h80000000, 32'd3);
    step();
    checks++; if (b0.out_score !== 32'h00000008) begin failures++; $display("FAIL negzero_score got=%h exp=00000008", b0.out_score); end
    checks++; if (b0.out_overflow !== 1'b0 || b0.out_class !== 1'b1) begin failures++; $display("FAIL negzero_ovf_class got=%b/%b exp=0/1", b0.out_overflow, b0.out_class); end
    ack();
  endtask

  task automatic test_bias();
    feed(32'd1, 32'd1, 32'd1, 32'd1);
    step();
    checks++; if (b1.out_score !== 32'hFFFFFFF4) begin failures++; $display("FAIL bias_score got=%h exp=fffffff4", b1.out_score); end
    checks++; if (b1.out_class !== 1'b0 || b1.out_overflow !== 1'b0) begin failures++; $display("FAIL bias_class_ovf got=%b/%b exp=0/0", b1.out_class, b1.out_overflow); end
    checks++; if (b0.out_score !== 32'h00000004) begin failures++; $display("FAIL bias_zero_score got=%h exp=00000004", b0.out_score); end
    ack();
  endtask

  task automatic test_overflow();
    feed(32'hFFFFFFFF, 32'd2, 32'd0, 32'd0);
    step();
    checks++; if (b0.out_score !== 32'h00000001) begin failures++; $display("FAIL ovf_score got=%h exp=00000001", b0.out_score); end
    checks++; if (b0.out_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", b0.out_overflow); end
    checks++; if (b1.out_score !== 32'hFFFFFFF1 || b1.out_overflow !== 1'b1) begin failures++; $display("FAIL ovf_bias got=%h/%b exp=fffffff1/1", b1.out_score, b1.out_overflow); end
    ack();
    feed(32'd1, 32'd1, 32'd1, 32'd1);
    step();
    checks++; if (b0.out_overflow !== 1'b0 || b0.out_score !== 32'h00000004) begin failures++; $display("FAIL ovf_cleared got=%b/%h exp=0/00000004", b0.out_overflow, b0.out_score); end
    ack();
  endtask

  task automatic test_backpressure();
    feed(32'd2, 32'd2, 32'd2, 32'd2);
    step();
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data = 32'd7;
      step();
      checks++; if (b0.out_valid !== 1'b1 || b0.out_score !== 32'h00000008) begin failures++; $display("FAIL bp_hold_%0d got=%b/%h exp=1/00000008", i, b0.out_valid, b0.out_score); end
      checks++; if (b0.in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_%0d got=%b exp=0", i, b0.in_ready); end
    end
    in_valid = 1'b0;
    in_data = '0;
    ack();
    feed(32'd1, 32'd1, 32'd1, 32'd1);
    step();
    checks++; if (b0.out_score !== 32'h00000004) begin failures++; $display("FAIL bp_next_score got=%h exp=00000004", b0.out_score); end
    ack();
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1;
    in_data = 32'd5;
    step();
    in_data = 32'd6;
    step();
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    checks++; if (b0.in_ready !== 1'b0 || b0.out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_ready_valid got=%b/%b exp=0/0", b0.in_ready, b0.out_valid); end
    reset = 1'b0;
    #1;
    checks++; if (b0.in_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_release got=%b exp=1", b0.in_ready); end
    feed(32'd1, 32'd2, 32'd3, 32'd4);
    step();
    checks++; if (b0.out_score !== 32'h0000000A) begin failures++; $display("FAIL mid_rst_fresh got=%h exp=0000000a", b0.out_score); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (b0.out_valid !== 1'b0 || b0.out_score !== 32'h0) begin failures++; $display("FAIL hold_rst got=%b/%h exp=0/00000000", b0.out_valid, b0.out_score); end
    feed(32'd3, 32'd3, 32'd3, 32'd3);
    step();
    checks++; if (b0.out_score !== 32'h0000000C) begin failures++; $display("FAIL hold_rst_next got=%h exp=0000000c", b0.out_score); end
    ack();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negzero();
    test_bias();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
